rca_result_buffer: RTL and testbench

- Sits directly downstream of the RCA execution unit and upstream of the Taiga writeback stage.
- Captures each RCA result (id + 32-bit value) into a small circular FIFO and presents it to writeback with a done/ack handshake.
- Generates issue-side backpressure by counting reserved slots, so the RCA never produces a result the buffer cannot hold.
- Lets the RCA keep single-cycle, fire-and-forget result pulses while writeback arbitration stalls.

---
 rtl/rca_result_buffer_pkg.sv | 15 +
 rtl/rca_result_fifo_mem.sv | 28 ++
 rtl/rca_result_buffer.sv | 132 +++++++++++++
 tb/tb_rca_result_buffer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rca_result_buffer_pkg.sv
// Shared types and constants for the RCA result buffer.
package rca_types;

  localparam int RCA_RESULT_DEPTH = 4;
  localparam int RCA_ID_W         = 3;
  localparam int RCA_DATA_W       = 32;

  typedef logic [RCA_ID_W-1:0] id_t;

  typedef struct packed {
    id_t         id;
    logic [31:0] data;
  } rca_result_t;

endpackage

// File: rtl/rca_result_fifo_mem.sv
// Result storage: DEPTH x WIDTH register array.
// It has one synchronous write port and one asynchronous read port.
// The data registers have no reset; validity is tracked by the control logic.
module rca_result_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the entry at the write pointer.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rca_result_buffer.sv
// RCA result buffer: a circular FIFO between the RCA unit and writeback.
//
// Handshakes:
//  - Issue side: issue_ready is a credit. An issue is accepted only when
//    issue_new_request and issue_ready are both high. Each accepted issue
//    reserves one slot until its result is acked.
//  - Result side: res_valid is a fire-and-forget pulse with no ready signal.
//    Credits guarantee a free slot. A result that arrives anyway while the
//    buffer is full, and no pop happens in the same cycle, is dropped and
//    sets the sticky overflow flag.
//  - Writeback side: wb_done is the valid signal and wb_ack is the ready
//    signal. The head entry transfers in a cycle where both are high.
//    wb_ack without wb_done is ignored.
module rca_result_buffer
  import rca_types::*;
#(
  parameter int DEPTH  = RCA_RESULT_DEPTH,
  parameter int DATA_W = 32,
  parameter int ID_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_new_request,
  output logic              issue_ready,
  input  logic              res_valid,
  input  logic [ID_W-1:0]   res_id,
  input  logic [DATA_W-1:0] res_data,
  output logic              wb_done,
  output logic [ID_W-1:0]   wb_id,
  output logic [DATA_W-1:0] wb_rd,
  input  logic              wb_ack,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ID_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reserved_q, reserved_d;
  logic             overflow_q, overflow_d;

  logic             pop;
  logic             push;
  logic             issue_acc;
  logic             mem_we;
  logic [ENT_W-1:0] head_entry;

  assign issue_ready = (reserved_q < CNT_FULL);
  assign pop         = wb_ack && (count_q != '0);
  // A pop in the same cycle frees the head slot before the write lands.
  assign push        = res_valid && ((count_q != CNT_FULL) || pop);
  assign issue_acc   = issue_new_request && issue_ready;
  assign mem_we      = push && !flush;

  rca_result_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i ({res_id, res_data}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  // Next-state logic for pointers, occupancy, reservations and overflow.
  // Flush takes precedence over every other event in the same cycle.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    reserved_d = reserved_q;
    overflow_d = overflow_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      reserved_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
      // Decrement is guarded so that results which were never issued cannot
      // underflow the reservation counter.
      if (issue_acc && !pop)                          reserved_d = reserved_q + CNT_ONE;
      else if (pop && !issue_acc && reserved_q != '0) reserved_d = reserved_q - CNT_ONE;
      if (res_valid && !push) overflow_d = 1'b1;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      reserved_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      reserved_q <= reserved_d;
      overflow_q <= overflow_d;
    end
  end

  // Head presentation comes only from registers and is zeroed when empty.
  always_comb begin
    wb_done = (count_q != '0);
    wb_id   = '0;
    wb_rd   = '0;
    if (wb_done) begin
      wb_id = head_entry[ENT_W-1:DATA_W];
      wb_rd = head_entry[DATA_W-1:0];
    end
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_rca_result_buffer.sv
// Self-checking bench for rca_result_buffer.
module tb_rca_result_buffer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ID_W   = 3;
  localparam int W      = ID_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              issue_new_request = 1'b0;
  logic              issue_ready;
  logic              res_valid = 1'b0;
  logic [ID_W-1:0]   res_id = '0;
  logic [DATA_W-1:0] res_data = '0;
  logic              wb_done;
  logic [ID_W-1:0]   wb_id;
  logic [DATA_W-1:0] wb_rd;
  logic              wb_ack = 1'b0;
  logic              overflow;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  rca_result_buffer #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .issue_new_request (issue_new_request),
    .issue_ready       (issue_ready),
    .res_valid         (res_valid),
    .res_id            (res_id),
    .res_data          (res_data),
    .wb_done           (wb_done),
    .wb_id             (wb_id),
    .wb_rd             (wb_rd),
    .wb_ack            (wb_ack),
    .overflow          (overflow)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Driver: inputs change just after the falling edge and hold for one cycle.
  task automatic drive(input logic iss, input logic rv, input logic [ID_W-1:0] id,
                       input logic [DATA_W-1:0] data, input logic ack, input logic fl,
                       input logic expect_push);
    @(negedge clk);
    issue_new_request = iss;
    res_valid         = rv;
    res_id            = id;
    res_data          = data;
    wb_ack            = ack;
    flush             = fl;
    if (fl) exp_q.delete();
    else if (rv && expect_push) exp_q.push_back({id, data});
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic issue();
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic result(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] data);
    drive(1'b0, 1'b1, id, data, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic ack();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Check the registered outputs of the state left by the previous cycle.
  task automatic check_flags(input string name, input logic done, input logic rdy,
                             input logic ovf);
    #1;
    check({name, ".wb_done"}, 32'(wb_done), 32'(done));
    check({name, ".issue_ready"}, 32'(issue_ready), 32'(rdy));
    check({name, ".overflow"}, 32'(overflow), 32'(ovf));
  endtask

  // Monitor: on every transfer of the head entry, pop the expected entry and compare.
  always @(negedge clk) begin
    #4;
    if (!rst && !flush && wb_done && wb_ack) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got id=%0d data=0x%0h required no entry", wb_id, wb_rd);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({wb_id, wb_rd} !== e) begin
          n_fail++;
          $display("FAIL head_entry: got id=%0d data=0x%0h required id=%0d data=0x%0h",
                   wb_id, wb_rd, e[W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle();
    check_flags("reset", 1'b0, 1'b1, 1'b0);
    check("reset.wb_id", 32'(wb_id), 32'd0);
    check("reset.wb_rd", wb_rd, 32'd0);

    // Single result: one-cycle latency and no bypass.
    issue();
    result(3'd3, 32'h15);
    #1 check("single.no_bypass", 32'(wb_done), 32'd0);
    idle();
    #1 check("single.wb_id", 32'(wb_id), 32'd3);
    check("single.wb_rd", wb_rd, 32'h15);
    ack();
    idle();
    check_flags("single.after_ack", 1'b0, 1'b1, 1'b0);

    // Backpressure: four issues exhaust the credits.
    for (int i = 0; i < 4; i++) issue();
    idle();
    check_flags("bp.full_credits", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) result(ID_W'(i), DATA_W'(10 + i));
    idle();
    check_flags("bp.held", 1'b1, 1'b0, 1'b0);
    ack();
    ack();
    check_flags("bp.credit_back", 1'b1, 1'b1, 1'b0);
    ack();
    ack();
    idle();
    check_flags("bp.drained", 1'b0, 1'b1, 1'b0);

    // Full buffer: an extra result with no pop is dropped and sets overflow.
    for (int i = 0; i < 4; i++) issue();
    for (int i = 0; i < 4; i++) result(ID_W'(4 + i), DATA_W'(32'h20 + i));
    result(3'd7, 32'hDEAD);
    exp_q.pop_back();
    idle();
    check_flags("full.overflow", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) ack();
    idle();
    check_flags("full.sticky", 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    idle();
    check_flags("full.flush_clears", 1'b0, 1'b1, 1'b0);

    // Wrap-around: issue, result and ack overlap, so occupancy stays small.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, ID_W'(i), DATA_W'(i), (i > 0), 1'b0, 1'b1);
      #1 check("wrap.ready", 32'(issue_ready), 32'd1);
    end
    ack();
    idle();
    check_flags("wrap.drained", 1'b0, 1'b1, 1'b0);

    // Flush with three entries held and four reserved; same-cycle events are discarded.
    for (int i = 0; i < 4; i++) issue();
    for (int i = 0; i < 3; i++) result(ID_W'(i + 1), DATA_W'(32'h40 + i));
    drive(1'b0, 1'b1, 3'd5, 32'h99, 1'b1, 1'b1, 1'b1);
    idle();
    check_flags("flush.cleared", 1'b0, 1'b1, 1'b0);
    check("flush.wb_id", 32'(wb_id), 32'd0);
    check("flush.wb_rd", wb_rd, 32'd0);
    ack();
    ack();
    check_flags("flush.nothing_later", 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in mid-cycle with two entries held.
    issue();
    issue();
    result(3'd2, 32'h51);
    result(3'd6, 32'h52);
    idle();
    check_flags("rst.before", 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    exp_q.delete();
    #1 check("rst.async.wb_done", 32'(wb_done), 32'd0);
    check("rst.async.issue_ready", 32'(issue_ready), 32'd1);
    check("rst.async.overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue();
    result(3'd1, 32'h77);
    ack();
    idle();
    check_flags("rst.resume", 1'b0, 1'b1, 1'b0);

    repeat (2) idle();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
